// File: rtl/aes_pkg.sv
// Shared definitions for the AES request arbiter: arbiter state encoding
// and AES block/key widths.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 128;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit scanning
// upward from the pointer, wrapping modulo NUM_REQ (NUM_REQ need not be a
// power of two, so the wrap is an explicit compare-and-subtract).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [ID_W-1:0]    i_Ptr,
  output logic               o_Any,
  output logic [NUM_REQ-1:0] o_OneHot,
  output logic [ID_W-1:0]    o_Idx
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  // Scan candidates ptr, ptr+1, ... and keep the first requesting one.
  always_comb begin
    o_Any    = 1'b0;
    o_OneHot = '0;
    o_Idx    = '0;
    sum      = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, i_Ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (!o_Any && i_Req[cand]) begin
        o_Any          = 1'b1;
        o_OneHot[cand] = 1'b1;
        o_Idx          = cand;
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares a single AES-128 core between NUM_REQ requesters: round-robin grant,
// capture of the winner's operands, core launch, watchdog, and a valid/ack
// result port tagged with the requester index. One job in flight at a time.
module aes_req_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic [NUM_REQ-1:0]         i_Req,
  input  logic [NUM_REQ-1:0]         i_Enc,
  input  logic [NUM_REQ*128-1:0]     i_Text,
  input  logic [NUM_REQ*128-1:0]     i_Key,
  output logic [NUM_REQ-1:0]         o_Gnt,
  output logic                       o_Valid,
  output logic [ID_W-1:0]            o_Id,
  output logic [127:0]               o_Data,
  output logic                       o_Err,
  input  logic                       i_Ack,
  output logic                       o_Busy,
  output logic                       o_CoreStart,
  output logic                       o_CoreEnc,
  output logic [127:0]               o_CoreText,
  output logic [127:0]               o_CoreKey,
  input  logic [127:0]               i_CoreData,
  input  logic                       i_CoreDone
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic                   err_q, err_d;
  logic                   enc_q, enc_d;
  logic [AES_BLOCK_W-1:0] text_q, text_d;
  logic [AES_KEY_W-1:0]   key_q, key_d;

  logic                   pick_any;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [ID_W-1:0]        pick_idx;

  logic [AES_BLOCK_W-1:0] text_arr [NUM_REQ];
  logic [AES_KEY_W-1:0]   key_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign text_arr[g] = i_Text[g*AES_BLOCK_W +: AES_BLOCK_W];
    assign key_arr[g]  = i_Key[g*AES_KEY_W +: AES_KEY_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_Req    (i_Req),
    .i_Ptr    (ptr_q),
    .o_Any    (pick_any),
    .o_OneHot (pick_onehot),
    .o_Idx    (pick_idx)
  );

  // Pointer moves one past the served requester, wrapping at NUM_REQ-1.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) next_ptr = '0;
    else                          next_ptr = id + 1'b1;
  endfunction

  // Next-state logic: grant/capture, launch, wait with watchdog, respond.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    enc_d   = enc_q;
    text_d  = text_q;
    key_d   = key_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          id_d    = pick_idx;
          enc_d   = i_Enc[pick_idx];
          text_d  = text_arr[pick_idx];
          key_d   = key_arr[pick_idx];
          state_d = ARB_START;
        end
      end
      ARB_START: begin
        cnt_d   = '0;
        state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        // A completion arriving on the last allowed cycle still counts.
        if (i_CoreDone) begin
          data_d  = i_CoreData;
          err_d   = 1'b0;
          state_d = ARB_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_RESP: begin
        if (i_Ack) begin
          ptr_d   = next_ptr(id_q);
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and capture registers; reset drops any in-flight job.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      enc_q   <= 1'b0;
      text_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
      enc_q   <= enc_d;
      text_q  <= text_d;
      key_q   <= key_d;
    end
  end

  assign o_Gnt       = (state_q == ARB_IDLE) ? pick_onehot : '0;
  assign o_Valid     = (state_q == ARB_RESP);
  assign o_Id        = id_q;
  assign o_Data      = data_q;
  assign o_Err       = err_q;
  assign o_Busy      = (state_q != ARB_IDLE);
  assign o_CoreStart = (state_q == ARB_START);
  assign o_CoreEnc   = enc_q;
  assign o_CoreText  = text_q;
  assign o_CoreKey   = key_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a behavioural AES core stand-in
// that knows the FIPS-197 AES-128 vector pair.
module tb_aes_req_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int CORE_LAT    = 5;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                   clk;
  logic                   rst;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     enc_v;
  logic [NUM_REQ*128-1:0] txt;
  logic [NUM_REQ*128-1:0] key_v;
  logic [NUM_REQ-1:0]     o_Gnt;
  logic                   o_Valid;
  logic [ID_W-1:0]        o_Id;
  logic [127:0]           o_Data;
  logic                   o_Err;
  logic                   ack;
  logic                   o_Busy;
  logic                   o_CoreStart;
  logic                   o_CoreEnc;
  logic [127:0]           o_CoreText;
  logic [127:0]           o_CoreKey;
  logic [127:0]           core_data;
  logic                   core_done;

  logic                   core_en;
  logic                   man_done;
  logic [127:0]           man_data;
  logic                   mdl_done;
  logic                   mdl_run;
  int                     mdl_cnt;
  logic [127:0]           mdl_data;

  int nerr = 0;
  int nchk = 0;
  int n;
  int order [5] = '{3, 0, 1, 2, 3};
  logic [127:0] exp_data;

  aes_req_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ID_W        (ID_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Req       (req),
    .i_Enc       (enc_v),
    .i_Text      (txt),
    .i_Key       (key_v),
    .o_Gnt       (o_Gnt),
    .o_Valid     (o_Valid),
    .o_Id        (o_Id),
    .o_Data      (o_Data),
    .o_Err       (o_Err),
    .i_Ack       (ack),
    .o_Busy      (o_Busy),
    .o_CoreStart (o_CoreStart),
    .o_CoreEnc   (o_CoreEnc),
    .o_CoreText  (o_CoreText),
    .o_CoreKey   (o_CoreKey),
    .i_CoreData  (core_data),
    .i_CoreDone  (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in core: known vectors map to their FIPS answers, anything else to
  // a fixed scramble so each requester gets a distinguishable result.
  function automatic logic [127:0] core_fn(input logic e, input logic [127:0] t,
                                           input logic [127:0] k);
    if (e && t == PT && k == KEY) return CT;
    if (!e && t == CT && k == KEY) return PT;
    return t ^ k ^ {128{e}};
  endfunction

  // Core model: done pulse CORE_LAT cycles after a sampled start.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_done <= 1'b0;
      mdl_run  <= 1'b0;
      mdl_cnt  <= 0;
      mdl_data <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (o_CoreStart && core_en) begin
        mdl_run <= 1'b1;
        mdl_cnt <= CORE_LAT;
      end else if (mdl_run) begin
        if (mdl_cnt == 1) begin
          mdl_done <= 1'b1;
          mdl_data <= core_fn(o_CoreEnc, o_CoreText, o_CoreKey);
          mdl_run  <= 1'b0;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end
    end
  end

  assign core_done = mdl_done | man_done;
  assign core_data = man_done ? man_data : mdl_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k;
    k = 0;
    while (!o_Valid && k < max) begin
      tick();
      k++;
    end
    check1({tag, "_valid_seen"}, o_Valid, 1'b1);
  endtask

  task automatic wait_gnt(input string tag, input int max);
    int k;
    k = 0;
    while (o_Gnt == '0 && k < max) begin
      tick();
      k++;
    end
    check1({tag, "_gnt_seen"}, |o_Gnt, 1'b1);
  endtask

  task automatic set_slot(input int k, input logic e, input logic [127:0] t);
    logic [NUM_REQ*128-1:0] m;
    logic [NUM_REQ*128-1:0] tv;
    logic [NUM_REQ*128-1:0] kv;
    m  = {{(NUM_REQ-1)*128{1'b0}}, {128{1'b1}}} << (128 * k);
    tv = {{(NUM_REQ-1)*128{1'b0}}, t} << (128 * k);
    kv = {{(NUM_REQ-1)*128{1'b0}}, KEY} << (128 * k);
    txt   = (txt & ~m) | tv;
    key_v = (key_v & ~m) | kv;
    enc_v = (enc_v & ~(NUM_REQ'(1) << k)) | (NUM_REQ'(e) << k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = '0; enc_v = '0; txt = '0; key_v = '0; ack = 1'b0;
    core_en = 1'b1; man_done = 1'b0; man_data = '0;
    #2;
    check("rst_gnt", 128'(o_Gnt), 128'(0));
    check1("rst_valid", o_Valid, 1'b0);
    check1("rst_busy", o_Busy, 1'b0);
    check1("rst_start", o_CoreStart, 1'b0);
    check("rst_ctext", o_CoreText, 128'(0));
    check("rst_data", o_Data, 128'(0));
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Single encrypt on requester 0.
    set_slot(0, 1'b1, PT);
    req = 4'b0001;
    #1;
    check("enc_gnt", 128'(o_Gnt), 128'(4'b0001));
    tick();
    req = '0;
    check("enc_gnt_pulse", 128'(o_Gnt), 128'(0));
    check1("enc_start", o_CoreStart, 1'b1);
    check("enc_ctext", o_CoreText, PT);
    check("enc_ckey", o_CoreKey, KEY);
    check1("enc_cenc", o_CoreEnc, 1'b1);
    tick();
    check1("enc_start_off", o_CoreStart, 1'b0);
    check1("enc_busy", o_Busy, 1'b1);
    wait_valid("enc", 40);
    check("enc_id", 128'(o_Id), 128'(0));
    check("enc_data", o_Data, CT);
    check1("enc_err", o_Err, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check1("enc_idle", o_Busy, 1'b0);
    check1("enc_valid_off", o_Valid, 1'b0);

    // Decrypt on requester 2 (pointer is now 1).
    set_slot(2, 1'b0, CT);
    req = 4'b0100;
    #1;
    check("dec_gnt", 128'(o_Gnt), 128'(4'b0100));
    tick();
    req = '0;
    check1("dec_cenc", o_CoreEnc, 1'b0);
    wait_valid("dec", 40);
    check("dec_id", 128'(o_Id), 128'(2));
    check("dec_data", o_Data, PT);
    check1("dec_err", o_Err, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Round robin with all requesting; pointer starts at 3.
    for (int k = 0; k < NUM_REQ; k++) set_slot(k, 1'b1, 128'h1000 + 128'(k));
    req = 4'b1111;
    ack = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      wait_gnt("rr", 40);
      check("rr_order", 128'(o_Gnt), 128'(4'b0001 << order[i]));
      check1("rr_no_overlap", o_Busy, 1'b0);
      tick();
      check("rr_pulse", 128'(o_Gnt), 128'(0));
    end
    req = '0;
    wait_valid("rr_last", 40);
    check("rr_last_id", 128'(o_Id), 128'(3));
    tick();
    ack = 1'b0;

    // Backpressure: requester 1 keeps requesting while its result waits.
    set_slot(1, 1'b1, 128'h0bad_f00d_0000_0000_1234_5678_9abc_def0);
    exp_data = core_fn(1'b1, 128'h0bad_f00d_0000_0000_1234_5678_9abc_def0, KEY);
    req = 4'b0010;
    #1;
    check("bp_gnt", 128'(o_Gnt), 128'(4'b0010));
    tick();
    wait_valid("bp", 40);
    repeat (20) begin
      check("bp_data", o_Data, exp_data);
      check("bp_ctl", 128'({o_Valid, o_Id, o_Gnt}), 128'({1'b1, 2'd1, 4'b0000}));
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("bp_regnt", 128'(o_Gnt), 128'(4'b0010));
    tick();
    req = '0;
    wait_valid("bp2", 40);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Watchdog: core never finishes.
    core_en = 1'b0;
    req = 4'b0001;
    #1;
    check("to_gnt", 128'(o_Gnt), 128'(4'b0001));
    tick();
    req = '0;
    n = 0;
    while (!o_Valid && n < 100) begin
      tick();
      n++;
    end
    check("to_latency", 128'(n), 128'(65));
    check1("to_err", o_Err, 1'b1);
    check("to_data", o_Data, 128'(0));
    check("to_id", 128'(o_Id), 128'(0));
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Done on the final watchdog cycle wins.
    req = 4'b0001;
    #1;
    check("dt_gnt", 128'(o_Gnt), 128'(4'b0001));
    tick();
    req = '0;
    repeat (64) tick();
    check1("dt_not_yet", o_Valid, 1'b0);
    man_data = 128'hcafe_babe_0000_1111_2222_3333_4444_5555;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check1("dt_valid", o_Valid, 1'b1);
    check1("dt_err", o_Err, 1'b0);
    check("dt_data", o_Data, 128'hcafe_babe_0000_1111_2222_3333_4444_5555);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Stray done in IDLE does nothing.
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check1("stray_busy", o_Busy, 1'b0);
    check1("stray_valid", o_Valid, 1'b0);

    // Reset in the middle of BUSY.
    core_en = 1'b1;
    set_slot(1, 1'b1, 128'h5555);
    req = 4'b0010;
    #1;
    check("mr_gnt", 128'(o_Gnt), 128'(4'b0010));
    tick();
    req = '0;
    tick();
    tick();
    check1("mr_busy_before", o_Busy, 1'b1);
    rst = 1'b0;
    #1;
    check1("mr_busy", o_Busy, 1'b0);
    check("mr_ctext", o_CoreText, 128'(0));
    check("mr_ckey", o_CoreKey, 128'(0));
    check1("mr_cenc", o_CoreEnc, 1'b0);
    check("mr_id", 128'(o_Id), 128'(0));
    check("mr_data", o_Data, 128'(0));
    tick();
    rst = 1'b1;
    set_slot(0, 1'b1, PT);
    req = 4'b0011;
    #1;
    check("mr_gnt_ptr0", 128'(o_Gnt), 128'(4'b0001));
    tick();
    req = '0;
    wait_valid("mr", 40);
    check("mr_resp_id", 128'(o_Id), 128'(0));
    check("mr_resp_data", o_Data, CT);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
